// File: rtl/ifetch_unit_if.sv
// rtl/ifetch_unit_if.sv - fetch-unit bus bundle: imem read port, redirect input, decode handshake
interface ifetch_unit_if #(
   parameter int XLEN = 32
);
   logic [XLEN-1:0] imem_rd_addr;
   logic [XLEN-1:0] imem_rd_data;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic            inst_valid;
   logic            inst_ready;
   logic [XLEN-1:0] inst_pc;
   logic [XLEN-1:0] inst_data;
   logic            inst_fault;

   modport master (
      output imem_rd_addr,
      input  imem_rd_data,
      input  redirect_valid,
      input  redirect_pc,
      output inst_valid,
      input  inst_ready,
      output inst_pc,
      output inst_data,
      output inst_fault
   );

   modport slave (
      input  imem_rd_addr,
      output imem_rd_data,
      output redirect_valid,
      output redirect_pc,
      input  inst_valid,
      output inst_ready,
      input  inst_pc,
      input  inst_data,
      input  inst_fault
   );
endinterface

// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - instruction fetch front-end with PC, 2-entry queue, redirect and misalign fault
module ifetch_unit #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int              QDEPTH   = 2
) (
   input  logic          clk,
   input  logic          cpu_rstn,
   ifetch_unit_if.master bus
);

   typedef enum logic [0:0] {ST_RUN, ST_HALT} state_t;

   localparam logic [2:0] QDEPTH_C = 3'(QDEPTH);

   state_t          state_q, state_d;
   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic            req_inflight_q, req_inflight_d;
   logic [XLEN-1:0] req_pc_q, req_pc_d;
   logic            rd_ptr_q, rd_ptr_d;
   logic            wr_ptr_q, wr_ptr_d;
   logic [1:0]      count_q, count_d;

   logic [XLEN-1:0] ent_pc_q    [2];
   logic [XLEN-1:0] ent_data_q  [2];
   logic            ent_fault_q [2];

   logic            pop;
   logic [2:0]      occupancy;
   logic            credit_ok;
   logic            misaligned;
   logic            push;
   logic [XLEN-1:0] push_pc;
   logic [XLEN-1:0] push_data;
   logic            push_fault;

   assign bus.imem_rd_addr = {2'b00, fetch_pc_q[XLEN-1:2]};
   assign bus.inst_valid   = (count_q != 2'd0);
   assign bus.inst_pc      = ent_pc_q[rd_ptr_q];
   assign bus.inst_data    = ent_data_q[rd_ptr_q];
   assign bus.inst_fault   = ent_fault_q[rd_ptr_q];

   assign pop        = bus.inst_valid & bus.inst_ready;
   // Slots already promised: queued entries plus the response still on its way back.
   assign occupancy  = {1'b0, count_q} + {2'b00, req_inflight_q} - {2'b00, pop};
   assign credit_ok  = (occupancy < QDEPTH_C);
   assign misaligned = (fetch_pc_q[1:0] != 2'b00);

   // Next-state logic: issue, response capture, fault insertion, queue pointers and redirect flush.
   always_comb begin
      state_d        = state_q;
      fetch_pc_d     = fetch_pc_q;
      req_inflight_d = 1'b0;
      req_pc_d       = req_pc_q;
      rd_ptr_d       = rd_ptr_q;
      wr_ptr_d       = wr_ptr_q;
      count_d        = count_q;
      push           = 1'b0;
      push_pc        = req_pc_q;
      push_data      = bus.imem_rd_data;
      push_fault     = 1'b0;

      if (bus.redirect_valid) begin
         // Flush wins over everything: drop queue, squash in-flight read, restart at target.
         fetch_pc_d = bus.redirect_pc;
         state_d    = ST_RUN;
         rd_ptr_d   = 1'b0;
         wr_ptr_d   = 1'b0;
         count_d    = 2'd0;
      end else begin
         if (req_inflight_q) begin
            push = 1'b1;
         end
         if (state_q == ST_RUN && credit_ok) begin
            if (misaligned) begin
               // Wait for any older response to land first so queue order matches PC order.
               if (!req_inflight_q) begin
                  push       = 1'b1;
                  push_pc    = fetch_pc_q;
                  push_data  = '0;
                  push_fault = 1'b1;
                  state_d    = ST_HALT;
               end
            end else begin
               req_inflight_d = 1'b1;
               req_pc_d       = fetch_pc_q;
               fetch_pc_d     = fetch_pc_q + {{(XLEN-3){1'b0}}, 3'd4};
            end
         end
         if (push) begin
            wr_ptr_d = ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
         end
         count_d = count_q + {1'b0, push} - {1'b0, pop};
      end
   end

   // Control state registers.
   always_ff @(posedge clk or negedge cpu_rstn) begin
      if (!cpu_rstn) begin
         state_q        <= ST_RUN;
         fetch_pc_q     <= RESET_PC;
         req_inflight_q <= 1'b0;
         req_pc_q       <= '0;
         rd_ptr_q       <= 1'b0;
         wr_ptr_q       <= 1'b0;
         count_q        <= 2'd0;
      end else begin
         state_q        <= state_d;
         fetch_pc_q     <= fetch_pc_d;
         req_inflight_q <= req_inflight_d;
         req_pc_q       <= req_pc_d;
         rd_ptr_q       <= rd_ptr_d;
         wr_ptr_q       <= wr_ptr_d;
         count_q        <= count_d;
      end
   end

   // Queue storage; cleared on reset so the head reads as zero while empty.
   always_ff @(posedge clk or negedge cpu_rstn) begin
      if (!cpu_rstn) begin
         for (int i = 0; i < 2; i++) begin
            ent_pc_q[i]    <= '0;
            ent_data_q[i]  <= '0;
            ent_fault_q[i] <= 1'b0;
         end
      end else if (push && !bus.redirect_valid) begin
         ent_pc_q[wr_ptr_q]    <= push_pc;
         ent_data_q[wr_ptr_q]  <= push_data;
         ent_fault_q[wr_ptr_q] <= push_fault;
      end
   end

   // Credit accounting must make a push into a full, non-draining queue impossible.
   assert property (@(posedge clk) disable iff (!cpu_rstn)
      !(push && !bus.redirect_valid && !pop && count_q == 2'd2))
      else $error("ifetch_unit queue overflow");

endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - scoreboard bench for ifetch_unit
module tb_ifetch_unit;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] data;
      logic        fault;
   } exp_t;

   logic clk;
   logic cpu_rstn;
   int   vectors;
   int   miscompares;
   exp_t sb[$];

   ifetch_unit_if #(.XLEN(32)) bus ();

   ifetch_unit #(
      .XLEN    (32),
      .RESET_PC(32'h0),
      .QDEPTH  (2)
   ) dut (
      .clk     (clk),
      .cpu_rstn(cpu_rstn),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous-read instruction memory: word k holds 32'h1000 + k.
   always @(posedge clk) bus.imem_rd_data <= 32'h1000 + bus.imem_rd_addr;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic expect_inst(input logic [31:0] pc, input logic fault);
      exp_t e;
      e.pc    = pc;
      e.fault = fault;
      e.data  = fault ? 32'h0 : (32'h1000 + (pc >> 2));
      sb.push_back(e);
   endtask

   // Monitor: every accepted head (not killed by a same-cycle redirect) must match the scoreboard.
   always @(negedge clk) begin
      if (cpu_rstn && bus.inst_valid && bus.inst_ready && !bus.redirect_valid) begin
         vectors++;
         if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_inst: got pc=%h data=%h fault=%b expected none",
                     bus.inst_pc, bus.inst_data, bus.inst_fault);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if (bus.inst_pc !== e.pc || bus.inst_data !== e.data || bus.inst_fault !== e.fault) begin
               miscompares++;
               $display("FAIL inst_stream: got pc=%h data=%h fault=%b expected pc=%h data=%h fault=%b",
                        bus.inst_pc, bus.inst_data, bus.inst_fault, e.pc, e.data, e.fault);
            end
         end
      end
   end

   // Assert reset (outputs must clear at once), then release just after a rising edge.
   task automatic do_reset();
      bus.inst_ready     = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 32'h0;
      cpu_rstn           = 1'b0;
      #1;
      chk("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
      chk("rst_inst_pc", bus.inst_pc, 32'h0);
      chk("rst_inst_data", bus.inst_data, 32'h0);
      chk("rst_inst_fault", 32'(bus.inst_fault), 32'd0);
      chk("rst_imem_addr", bus.imem_rd_addr, 32'h0);
      repeat (2) @(posedge clk);
      #1 cpu_rstn = 1'b1;
   endtask

   initial begin
      vectors            = 0;
      miscompares        = 0;
      cpu_rstn           = 1'b1;
      bus.inst_ready     = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 32'h0;
      #3;

      // Streaming from reset, then a mid-stream reset with two entries queued.
      do_reset();
      expect_inst(32'h0, 1'b0);
      expect_inst(32'h4, 1'b0);
      expect_inst(32'h8, 1'b0);
      expect_inst(32'hC, 1'b0);
      for (int c = 0; c < 6; c++) begin
         bus.inst_ready = 1'b1;
         @(negedge clk);
         chk($sformatf("A_addr_c%0d", c), bus.imem_rd_addr, 32'(c));
         chk($sformatf("A_valid_c%0d", c), 32'(bus.inst_valid), 32'(c >= 2));
         @(posedge clk); #1;
      end
      bus.inst_ready = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      chk("A_full_valid", 32'(bus.inst_valid), 32'd1);
      chk("A_full_head_pc", bus.inst_pc, 32'h10);

      // Stall for 5 cycles after first valid, then drain back to back.
      do_reset();
      expect_inst(32'h0, 1'b0);
      expect_inst(32'h4, 1'b0);
      expect_inst(32'h8, 1'b0);
      expect_inst(32'hC, 1'b0);
      for (int c = 0; c < 11; c++) begin
         bus.inst_ready = (c >= 7);
         @(negedge clk);
         if (c >= 2 && c <= 6) begin
            chk($sformatf("B_hold_pc_c%0d", c), bus.inst_pc, 32'h0);
            chk($sformatf("B_hold_data_c%0d", c), bus.inst_data, 32'h1000);
            chk($sformatf("B_noissue_addr_c%0d", c), bus.imem_rd_addr, 32'h2);
         end
         @(posedge clk); #1;
      end

      // Redirect to 0x40 with an entry queued and a request in flight.
      do_reset();
      expect_inst(32'h40, 1'b0);
      expect_inst(32'h44, 1'b0);
      expect_inst(32'h48, 1'b0);
      expect_inst(32'h4C, 1'b0);
      for (int c = 0; c < 9; c++) begin
         bus.inst_ready     = (c >= 3);
         bus.redirect_valid = (c == 2);
         bus.redirect_pc    = 32'h40;
         @(negedge clk);
         if (c == 3 || c == 4) chk($sformatf("C_valid_low_c%0d", c), 32'(bus.inst_valid), 32'd0);
         if (c == 3) chk("C_addr_target", bus.imem_rd_addr, 32'h10);
         if (c == 5) chk("C_valid_at_3", 32'(bus.inst_valid), 32'd1);
         @(posedge clk); #1;
      end

      // Redirect coinciding with a pop and an arriving response.
      do_reset();
      expect_inst(32'h0, 1'b0);
      expect_inst(32'h100, 1'b0);
      expect_inst(32'h104, 1'b0);
      expect_inst(32'h108, 1'b0);
      for (int c = 0; c < 9; c++) begin
         bus.inst_ready     = 1'b1;
         bus.redirect_valid = (c == 3);
         bus.redirect_pc    = 32'h100;
         @(negedge clk);
         if (c == 4 || c == 5) chk($sformatf("D_valid_low_c%0d", c), 32'(bus.inst_valid), 32'd0);
         @(posedge clk); #1;
      end

      // Misaligned redirect faults and halts; a second misaligned one faults again; 0x80 resumes.
      do_reset();
      expect_inst(32'h22, 1'b1);
      expect_inst(32'h31, 1'b1);
      expect_inst(32'h80, 1'b0);
      expect_inst(32'h84, 1'b0);
      for (int c = 0; c < 17; c++) begin
         bus.inst_ready     = 1'b1;
         bus.redirect_valid = (c == 0 || c == 8 || c == 12);
         bus.redirect_pc    = (c == 0) ? 32'h22 : (c == 8) ? 32'h31 : 32'h80;
         @(negedge clk);
         if (c >= 3 && c <= 8) begin
            chk($sformatf("E_halt_valid_c%0d", c), 32'(bus.inst_valid), 32'd0);
            chk($sformatf("E_halt_addr_c%0d", c), bus.imem_rd_addr, 32'h8);
         end
         if (c == 11) chk("E_valid_low_c11", 32'(bus.inst_valid), 32'd0);
         if (c == 15) chk("E_resume_fault", 32'(bus.inst_fault), 32'd0);
         @(posedge clk); #1;
      end

      // PC wraps from 0xFFFFFFFC to 0.
      do_reset();
      expect_inst(32'hFFFF_FFF8, 1'b0);
      expect_inst(32'hFFFF_FFFC, 1'b0);
      expect_inst(32'h0, 1'b0);
      expect_inst(32'h4, 1'b0);
      for (int c = 0; c < 7; c++) begin
         bus.inst_ready     = 1'b1;
         bus.redirect_valid = (c == 0);
         bus.redirect_pc    = 32'hFFFF_FFF8;
         @(negedge clk);
         if (c == 2) chk("F_addr_top", bus.imem_rd_addr, 32'h3FFF_FFFF);
         if (c == 3) chk("F_addr_wrap", bus.imem_rd_addr, 32'h0);
         @(posedge clk); #1;
      end
      bus.inst_ready = 1'b0;
      @(posedge clk); #1;

      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
